// File: rtl/bench_result_uart.sv
// Result reporter: buffers 32-bit words in a small FIFO and sends each one as
// eight uppercase ASCII hex digits plus CR LF on a UART 8N1 line.
module bench_result_uart #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        result_valid,
  input  logic [31:0] result_data,
  output logic        result_ready,
  output logic        tx,
  output logic        busy,
  output logic        overflow,
  output logic        led
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [3:0]    char_idx_q, char_idx_d;
  logic [31:0]   word_q, word_d;
  logic          tx_q, tx_d;
  logic          led_q, led_d;
  logic          ovf_q, ovf_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic        full, empty, push, pop, cnt_done;
  logic [31:0] shifted;
  logic [3:0]  nib;
  logic [7:0]  char_byte;

  assign full     = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign push     = result_valid && !full;
  assign pop      = (state_q == IDLE) && !empty;
  assign cnt_done = (cnt_q == CNT_LAST);

  // Character 0..7 is a hex digit (MSB nibble first), then CR, then LF.
  always_comb begin
    shifted = word_q >> {char_idx_q[2:0] ^ 3'b111, 2'b00};
    nib     = shifted[3:0];
    case (char_idx_q)
      4'd8:    char_byte = 8'h0D;
      4'd9:    char_byte = 8'h0A;
      default: char_byte = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    char_idx_d = char_idx_q;
    word_d     = word_q;
    tx_d       = tx_q;
    led_d      = led_q;
    ovf_d      = ovf_q | (result_valid & full);
    wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d    = START;
          word_d     = mem_q[rd_ptr_q[AW-1:0]];
          char_idx_d = 4'd0;
          cnt_d      = '0;
          tx_d       = 1'b0;
        end
      end
      START: begin
        if (cnt_done) begin
          state_d   = DATA;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          tx_d      = char_byte[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = char_byte[bit_idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (char_idx_q == 4'd9) begin
            state_d = IDLE;
            led_d   = ~led_q;
          end else begin
            state_d    = START;
            char_idx_d = char_idx_q + 4'd1;
            tx_d       = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      char_idx_q <= '0;
      word_q     <= '0;
      tx_q       <= 1'b1;
      led_q      <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      char_idx_q <= char_idx_d;
      word_q     <= word_d;
      tx_q       <= tx_d;
      led_q      <= led_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= result_data;
    end
  end

  assign result_ready = !full;
  assign tx           = tx_q;
  assign busy         = (state_q != IDLE);
  assign overflow     = ovf_q;
  assign led          = led_q;

endmodule
